// File: rtl/ts_tx_serializer_pkg.sv
// Shared TS symbol constants and serializer types.
// Common to the TS generator, serializer and analyser.
package ts_tx_serializer_pkg;

    localparam logic [7:0] COM          = 8'hBC;
    localparam logic [7:0] PADG12       = 8'hF7;
    localparam logic [7:0] D10_2        = 8'h4A;
    localparam logic [7:0] D5_2         = 8'h45;
    localparam logic [7:0] RATE_SUPPORT = 8'h02;

    localparam int DIV_G1_DEF = 4;
    localparam int DIV_G2_DEF = 2;

    typedef enum logic {
        ST_IDLE,
        ST_SEND
    } tx_state_e;

endpackage

// File: rtl/ts_tx_serializer_if.sv
// Generator-side and lane-side bundle of the serializer.
// master = generator/lane side, slave = serializer.
interface ts_tx_serializer_if;

    logic         ts_valid;
    logic [127:0] ts;
    logic         speed;
    logic         ts_tx_fifo_full;
    logic [7:0]   sym;
    logic         sym_k;
    logic         sym_valid;
    logic         sym_sos;
    logic         tx_idle;
    logic [15:0]  os_sent_cnt;
    logic         overflow;

    modport master (
        output ts_valid, ts, speed,
        input  ts_tx_fifo_full, sym, sym_k, sym_valid,
        input  sym_sos, tx_idle, os_sent_cnt, overflow
    );

    modport slave (
        input  ts_valid, ts, speed,
        output ts_tx_fifo_full, sym, sym_k, sym_valid,
        output sym_sos, tx_idle, os_sent_cnt, overflow
    );

endinterface

// File: rtl/ts_tx_serializer_os_fifo.sv
// 128-bit ordered-set FIFO with count, registered
// almost-full flag and sticky overflow.
module ts_os_fifo
    import ts_tx_serializer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_i,
    input  logic [127:0]             data_i,
    input  logic                     rd_i,
    output logic [127:0]             data_o,
    output logic                     empty_o,
    output logic                     empty_next_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     overflow_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [127:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          full_q, full_d;
    logic          ovf_q, ovf_d;
    logic          wr_en, rd_en;

    // Accept/pop qualification, count and flag next-state.
    always_comb begin
        wr_en    = wr_i && (count_q < CW'(DEPTH));
        rd_en    = rd_i && (count_q != '0);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        unique case ({wr_en, rd_en})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (wr_i && !wr_en) begin
            ovf_d = 1'b1;
        end
        // One entry of margin for the generator's registered reaction.
        full_d = (count_d >= CW'(DEPTH - 1));
    end

    // Pointer, count and flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage array; contents are don't-care while empty.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    assign data_o       = mem_q[rd_ptr_q];
    assign empty_o      = (count_q == '0);
    assign empty_next_o = (count_d == '0);
    assign count_o      = count_q;
    assign full_o       = full_q;
    assign overflow_o   = ovf_q;

endmodule

// File: rtl/ts_tx_serializer.sv
// Buffers TS ordered sets and serialises them onto an
// 8-bit symbol stream with speed-dependent pacing.
module ts_tx_serializer
    import ts_tx_serializer_pkg::*;
#(
    parameter int         DEPTH   = 4,
    parameter int         DIV_G1  = DIV_G1_DEF,
    parameter int         DIV_G2  = DIV_G2_DEF,
    parameter logic [7:0] COM_SYM = COM,
    parameter logic [7:0] PAD_SYM = PADG12
) (
    input  logic              clk,
    input  logic              rst,
    ts_tx_serializer_if.slave bus
);

    localparam int DMAX = (DIV_G1 > DIV_G2) ? DIV_G1 : DIV_G2;
    localparam int DW   = $clog2(DMAX + 1);

    tx_state_e     state_q, state_d;
    logic [127:0]  shift_q, shift_d;
    logic [3:0]    idx_q, idx_d;
    logic [DW-1:0] div_q, div_d;
    logic [DW-1:0] cnt_q, cnt_d;
    logic [7:0]    sym_q, sym_d;
    logic          k_q, k_d;
    logic          sv_q, sv_d;
    logic          sos_q, sos_d;
    logic          idle_q, idle_d;
    logic [15:0]   os_cnt_q, os_cnt_d;

    logic          pop, load, adv, done;
    logic [127:0]  head;
    logic          empty, empty_next;
    logic [$clog2(DEPTH):0] count;

    ts_os_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .wr_i         (bus.ts_valid),
        .data_i       (bus.ts),
        .rd_i         (pop),
        .data_o       (head),
        .empty_o      (empty),
        .empty_next_o (empty_next),
        .count_o      (count),
        .full_o       (bus.ts_tx_fifo_full),
        .overflow_o   (bus.overflow)
    );

    // Slot sequencing; a new symbol is registered at slot start.
    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        idx_d    = idx_q;
        div_d    = div_q;
        cnt_d    = cnt_q;
        sym_d    = sym_q;
        k_d      = k_q;
        sv_d     = 1'b0;
        sos_d    = sos_q;
        os_cnt_d = os_cnt_q;
        pop      = 1'b0;
        load     = 1'b0;
        adv      = 1'b0;
        done     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (!empty) begin
                    load    = 1'b1;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (cnt_q == div_q - 1'b1) begin
                    if (idx_q == 4'd15) begin
                        done = 1'b1;
                        if (!empty) begin
                            load = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        adv = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        endcase
        // Speed is only sampled when an ordered set starts.
        if (load) begin
            pop     = 1'b1;
            shift_d = head;
            div_d   = bus.speed ? DW'(DIV_G2) : DW'(DIV_G1);
            idx_d   = 4'd0;
            cnt_d   = '0;
            sv_d    = 1'b1;
            sym_d   = head[127:120];
            sos_d   = 1'b1;
        end
        if (adv) begin
            shift_d = {shift_q[119:0], 8'h00};
            idx_d   = idx_q + 4'd1;
            cnt_d   = '0;
            sv_d    = 1'b1;
            sym_d   = shift_q[119:112];
            sos_d   = 1'b0;
        end
        if (sv_d) begin
            k_d = (sym_d == COM_SYM) || (sym_d == PAD_SYM);
        end
        if (done && (os_cnt_q != 16'hFFFF)) begin
            os_cnt_d = os_cnt_q + 16'd1;
        end
        idle_d = (state_d == ST_IDLE) && empty_next;
    end

    // Serializer state and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            shift_q  <= '0;
            idx_q    <= 4'd0;
            div_q    <= DW'(DIV_G1);
            cnt_q    <= '0;
            sym_q    <= 8'h00;
            k_q      <= 1'b0;
            sv_q     <= 1'b0;
            sos_q    <= 1'b0;
            idle_q   <= 1'b1;
            os_cnt_q <= 16'h0000;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            idx_q    <= idx_d;
            div_q    <= div_d;
            cnt_q    <= cnt_d;
            sym_q    <= sym_d;
            k_q      <= k_d;
            sv_q     <= sv_d;
            sos_q    <= sos_d;
            idle_q   <= idle_d;
            os_cnt_q <= os_cnt_d;
        end
    end

    assign bus.sym         = sym_q;
    assign bus.sym_k       = k_q;
    assign bus.sym_valid   = sv_q;
    assign bus.sym_sos     = sos_q;
    assign bus.tx_idle     = idle_q;
    assign bus.os_sent_cnt = os_cnt_q;

endmodule

// File: tb/tb_ts_tx_serializer.sv
// Directed self-checking bench for ts_tx_serializer.
// Symbol strobes are logged with their cycle stamp.
module tb_ts_tx_serializer;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   nchk = 0;
    int   nerr = 0;

    ts_tx_serializer_if bus ();

    ts_tx_serializer #(
        .DEPTH (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic       sos;
        logic       k;
        logic [7:0] s;
        int         t;
    } rec_t;

    rec_t q[$];

    always @(negedge clk) begin
        if (bus.sym_valid === 1'b1) begin
            q.push_back('{bus.sym_sos, bus.sym_k, bus.sym, cyc});
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        nchk++;
        assert (got === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] mkset(input logic [3:0] j);
        logic [127:0] v;
        v = '0;
        for (int i = 0; i < 16; i++) begin
            v[127-8*i -: 8] = (i == 0) ? 8'hBC : {j, 4'(i)};
        end
        return v;
    endfunction

    task automatic chk_set(input string tag, input int base,
                           input logic [127:0] d, input logic [15:0] km,
                           input int t0, input int sp);
        logic [7:0] e;
        for (int i = 0; i < 16; i++) begin
            e = d[127-8*i -: 8];
            if (base + i < q.size()) begin
                chk({tag, ".sym"}, q[base+i].s, e);
                chk({tag, ".k"}, q[base+i].k, km[15-i]);
                chk({tag, ".sos"}, q[base+i].sos, i == 0);
                chk({tag, ".time"}, q[base+i].t, t0 + sp * i);
            end else begin
                chk({tag, ".missing"}, q.size(), base + i + 1);
            end
        end
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        @(negedge clk);
        while (bus.tx_idle !== 1'b1) begin
            @(negedge clk);
            n++;
            if (n > budget) begin
                chk("wait_idle.timeout", 0, 1);
                break;
            end
        end
    endtask

    task automatic wait_syms(input int cnt, input int budget);
        int n;
        n = 0;
        while (q.size() < cnt) begin
            @(posedge clk);
            n++;
            if (n > budget) begin
                chk("wait_syms.timeout", q.size(), cnt);
                break;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst          = 1'b1;
        bus.ts_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        q.delete();
    endtask

    task automatic send(input logic [127:0] d);
        bus.ts_valid = 1'b1;
        bus.ts       = d;
        @(negedge clk);
        bus.ts_valid = 1'b0;
    endtask

    logic [127:0] t1;
    logic [3:0]   tag;
    logic         pf;
    int           c;

    initial begin
        rst          = 1'b1;
        bus.ts_valid = 1'b0;
        bus.ts       = '0;
        bus.speed    = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst.sym", bus.sym, 8'h00);
        chk("rst.sym_k", bus.sym_k, 0);
        chk("rst.sym_valid", bus.sym_valid, 0);
        chk("rst.sym_sos", bus.sym_sos, 0);
        chk("rst.tx_idle", bus.tx_idle, 1);
        chk("rst.os_cnt", bus.os_sent_cnt, 0);
        chk("rst.overflow", bus.overflow, 0);
        chk("rst.full", bus.ts_tx_fifo_full, 0);

        // single OS, Gen1 pacing
        t1 = {8'hBC, 8'hF7, 8'hF7, 8'hFF, 8'h02, 8'h00, {10{8'h4A}}};
        @(negedge clk);
        c = cyc;
        send(t1);
        wait_idle(200);
        chk("t1.count", q.size(), 16);
        chk_set("t1", 0, t1, 16'hE000, c + 2, 4);
        chk("t1.os_cnt", bus.os_sent_cnt, 1);
        chk("t1.idle", bus.tx_idle, 1);
        chk("t1.hold_sym", bus.sym, 8'h4A);
        chk("t1.hold_valid", bus.sym_valid, 0);

        // back-to-back, Gen2 pacing
        do_reset();
        bus.speed = 1'b1;
        @(negedge clk);
        c = cyc;
        bus.ts_valid = 1'b1;
        for (int j = 1; j <= 3; j++) begin
            bus.ts = mkset(4'(j));
            @(negedge clk);
        end
        bus.ts_valid = 1'b0;
        wait_idle(400);
        chk("t2.count", q.size(), 48);
        chk_set("t2.s1", 0, mkset(4'd1), 16'h8000, c + 2, 2);
        chk_set("t2.s2", 16, mkset(4'd2), 16'h8000, c + 34, 2);
        chk_set("t2.s3", 32, mkset(4'd3), 16'h8000, c + 66, 2);
        chk("t2.os_cnt", bus.os_sent_cnt, 3);

        // back-pressure with a one-cycle-lag generator
        do_reset();
        bus.speed = 1'b0;
        pf  = 1'b0;
        tag = 4'd1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            bus.ts_valid = !pf;
            bus.ts       = mkset(tag);
            if (!pf) tag = tag + 4'd1;
            pf = bus.ts_tx_fifo_full;
        end
        @(negedge clk);
        bus.ts_valid = 1'b0;
        chk("t3.writes", tag, 4'd6);
        chk("t3.fifo_cnt", dut.u_fifo.count_q, 4);
        chk("t3.full", bus.ts_tx_fifo_full, 1);
        chk("t3.ovf_clear", bus.overflow, 0);
        send(mkset(4'd9));
        chk("t3.ovf_set", bus.overflow, 1);
        chk("t3.fifo_cnt2", dut.u_fifo.count_q, 4);
        wait_idle(1000);
        chk("t3.count", q.size(), 80);
        chk("t3.os_cnt", bus.os_sent_cnt, 5);
        chk("t3.ovf_sticky", bus.overflow, 1);
        chk("t3.full_end", bus.ts_tx_fifo_full, 0);
        for (int n = 0; n < 5; n++) begin
            if (16 * n + 1 < q.size()) begin
                chk("t3.order", q[16*n+1].s, {4'(n + 1), 4'h1});
                chk("t3.sos", q[16*n].sos, 1);
            end
        end

        // speed change mid-OS
        do_reset();
        bus.speed = 1'b0;
        @(negedge clk);
        c = cyc;
        bus.ts_valid = 1'b1;
        bus.ts       = mkset(4'd1);
        @(negedge clk);
        bus.ts       = mkset(4'd2);
        @(negedge clk);
        bus.ts_valid = 1'b0;
        wait_syms(8, 100);
        @(negedge clk);
        bus.speed = 1'b1;
        wait_idle(400);
        chk("t4.count", q.size(), 32);
        chk_set("t4.s1", 0, mkset(4'd1), 16'h8000, c + 2, 4);
        chk_set("t4.s2", 16, mkset(4'd2), 16'h8000, c + 66, 2);

        // reset mid-OS
        do_reset();
        bus.speed = 1'b0;
        @(negedge clk);
        bus.ts_valid = 1'b1;
        bus.ts       = mkset(4'd1);
        @(negedge clk);
        bus.ts       = mkset(4'd2);
        @(negedge clk);
        bus.ts_valid = 1'b0;
        wait_syms(10, 200);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t5.sym", bus.sym, 8'h00);
        chk("t5.sym_k", bus.sym_k, 0);
        chk("t5.sym_valid", bus.sym_valid, 0);
        chk("t5.sym_sos", bus.sym_sos, 0);
        chk("t5.idle", bus.tx_idle, 1);
        chk("t5.full", bus.ts_tx_fifo_full, 0);
        chk("t5.fifo_cnt", dut.u_fifo.count_q, 0);
        chk("t5.count_at_rst", q.size(), 10);
        repeat (150) @(negedge clk);
        chk("t5.no_more", q.size(), 10);
        chk("t5.os_cnt", bus.os_sent_cnt, 0);
        chk("t5.idle_end", bus.tx_idle, 1);

        // counter saturation
        do_reset();
        @(negedge clk);
        force dut.os_cnt_q = 16'hFFFE;
        @(negedge clk);
        release dut.os_cnt_q;
        @(negedge clk);
        chk("t6.preload", bus.os_sent_cnt, 16'hFFFE);
        bus.speed = 1'b1;
        bus.ts_valid = 1'b1;
        for (int j = 1; j <= 3; j++) begin
            bus.ts = mkset(4'(j));
            @(negedge clk);
        end
        bus.ts_valid = 1'b0;
        wait_idle(400);
        chk("t6.count", q.size(), 48);
        chk("t6.sat", bus.os_sent_cnt, 16'hFFFF);
        repeat (5) @(negedge clk);
        chk("t6.hold", bus.os_sent_cnt, 16'hFFFF);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/ts_tx_serializer.md
Name: ts_tx_serializer

Overview:
- Sits directly downstream of the TS generator, between it and the lane/PHY model.
- Accepts 128-bit ordered sets (16 symbols) on a valid strobe into a small FIFO and back-pressures the generator with a registered full flag.
- Serialises each buffered ordered set onto an 8-bit symbol stream, symbol 0 first, tagging K-characters.
- Symbol pacing depends on link speed.

Parameters:
- DEPTH, 4, FIFO entries (128-bit each); power of 2, minimum 2.
- DIV_G1, 4, clk cycles per symbol when speed=0.
- DIV_G2, 2, clk cycles per symbol when speed=1.
- COM_SYM, 8'hBC, symbol value flagged as K (comma).
- PAD_SYM, 8'hF7, symbol value flagged as K (PAD).

Ports:
- clk  in  1  system clock (1 GHz).
- rst  in  1  synchronous reset, active-high.
- ts_valid  in  1  one ordered set offered this cycle.
- ts  in  128  ordered set; [127:120]=symbol 0 … [7:0]=symbol 15.
- speed  in  1  0=Gen1 pacing, 1=Gen2 pacing.
- ts_tx_fifo_full  out  1  back-pressure to generator (registered).
- sym  out  8  current transmitted symbol.
- sym_k  out  1  sym is a K-character.
- sym_valid  out  1  sym is valid this cycle (one-cycle strobe per symbol).
- sym_sos  out  1  qualifies symbol 0 of an ordered set.
- tx_idle  out  1  no ordered set in flight and FIFO empty.
- os_sent_cnt  out  16  ordered sets fully serialised; saturates at 16'hFFFF.
- overflow  out  1  sticky; a write was dropped because the FIFO was full.

Behaviour:
- Reset state:
  - FIFO empty, pointers 0.
  - ts_tx_fifo_full=0, sym=0, sym_k=0, sym_valid=0, sym_sos=0, tx_idle=1, os_sent_cnt=0, overflow=0.
  - FSM in IDLE.
- Write:
  - Accepted when ts_valid=1 and count<DEPTH.
  - ts_valid=1 with count==DEPTH drops the data and sets overflow (sticky until rst).
- Full flag:
  - Registered: ts_tx_fifo_full <= (next_count >= DEPTH-1).
  - The one-entry margin covers the generator's one-cycle registered reaction.
- Simultaneous read and write at any count:
  - Both occur; count unchanged.
  - A write at count==DEPTH is still dropped even if a pop happens the same cycle.
- FSM states:
  - IDLE:
    - If FIFO not empty: pop head into a 128-bit shift register, latch the divider as DIV_G2 if speed=1 else DIV_G1, set idx=0 and div_cnt=0, go to SEND.
    - Pop-to-first-symbol latency: 1 cycle after entry into the FIFO when idle. A write at cycle N gives sym_valid at cycle N+2.
  - SEND:
    - div_cnt counts 0..div-1.
    - When div_cnt==0: sym_valid=1 for one cycle with sym=shift[127:120]; sym_k=(sym==COM_SYM or sym==PAD_SYM); sym_sos=(idx==0).
    - When div_cnt==div-1: shift left 8, idx++.
    - After idx 15's slot completes:
      - If the FIFO is not empty, pop the next entry and continue back-to-back. There is no gap: the next symbol 0 lands exactly div cycles after symbol 15.
      - Otherwise go to IDLE.
      - In both cases os_sent_cnt increments (saturating).
- Output hold: sym, sym_k and sym_sos hold their values between strobes. sym_sos is only meaningful with sym_valid.
- speed is sampled only at ordered-set start. A change mid-set takes effect on the next set.
- tx_idle=1 iff state==IDLE and FIFO empty (registered).
- Reset mid-ordered-set: aborts immediately; no partial completion; os_sent_cnt is not incremented.
- Widths: count is $clog2(DEPTH)+1 bits. Pointers wrap modulo DEPTH.

Decomposition:
- Shared define/package: COM, PADG12, D10_2 and D5_2 symbol constants, RATE_SUPPORT, and the DIV_G1/DIV_G2 defaults. These are shared with the TS generator and TS analyser.
- One natural sub-module: ts_os_fifo.
  - Parameterised 128-bit synchronous FIFO with count, registered almost-full flag and overflow flag.
  - The FSM/shift register stays in the top.

Test Plan:
- Single OS at speed=0: one ts_valid pulse with ts={BC,F7,F7,FF,02,00,4A×10} → 16 sym_valid strobes spaced 4 cycles apart.
  - First strobe 2 cycles after the write; sym_sos on BC only.
  - sym_k=1 on symbols 0–2 only.
  - os_sent_cnt=1; tx_idle returns to 1.
- Back-to-back at speed=1: 3 consecutive ts_valid writes → 48 symbols at 2-cycle spacing with no gap between sets; os_sent_cnt=3.
- Back-pressure with DEPTH=4, speed=0: ts_valid held high continuously → full asserts once count reaches 3.
  - A generator model honouring full with a 1-cycle lag must see overflow stay 0.
  - Forcing a 5th write while count==4 → overflow=1 and the data is not serialised.
- Speed change mid-OS: speed toggles 0→1 at symbol 7 → the remainder of that set stays at 4-cycle spacing; the next set uses 2-cycle spacing.
- Reset mid-OS: assert rst for 1 cycle at symbol 9 → next cycle has all outputs at reset values and an empty FIFO; no further sym_valid; os_sent_cnt=0.
- Saturation: preload os_sent_cnt via force to 16'hFFFE, send 3 OS → reads 16'hFFFF and holds.
